softex_streamer_sched: RTL and testbench

SOFTEX_STREAMER_SCHED -- requirements
Module: softex_streamer_sched

---
 rtl/softex_streamer_sched_if.sv | 28 ++
 rtl/softex_streamer_sched.sv | 166 ++++++++++++++++
 tb/tb_softex_streamer_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softex_streamer_sched_if.sv
// Load/store stream handshake bundle between the streamer scheduler and the two DMA streams.
interface softex_streamer_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  in_req_start_o;
    logic [ADDR_WIDTH-1:0] in_addr_o;
    logic [LEN_WIDTH-1:0]  in_len_o;
    logic                  in_done_i;
    logic                  out_req_start_o;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [LEN_WIDTH-1:0]  out_len_o;
    logic                  out_done_i;

    modport master (
        output in_req_start_o, in_addr_o, in_len_o,
        input  in_done_i,
        output out_req_start_o, out_addr_o, out_len_o,
        input  out_done_i
    );

    modport slave (
        input  in_req_start_o, in_addr_o, in_len_o,
        output in_done_i,
        input  out_req_start_o, out_addr_o, out_len_o,
        output out_done_i
    );
endinterface

// File: rtl/softex_streamer_sched.sv
// Row scheduler: issues per-row load and store stream requests, keeping loads at most two rows
// ahead of completed stores, with strided addresses produced by accumulators.
module softex_streamer_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ROW_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] in_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    input  logic [LEN_WIDTH-1:0]  row_len_i,
    input  logic [ROW_WIDTH-1:0]  n_rows_i,
    softex_streamer_sched_if.master strm,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ROW_WIDTH-1:0]  rows_done_o
);
    // state  | meaning
    // S_IDLE | waiting for start_i, last job's rows_done held
    // S_RUN  | issuing and tracking row loads/stores
    // S_DONE | one-cycle job-complete pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);
    localparam logic [ROW_WIDTH-1:0] ROW_TWO = ROW_WIDTH'(2);

    state_t                r_state;
    logic [ROW_WIDTH-1:0]  r_n_rows;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_in_acc;
    logic [ADDR_WIDTH-1:0] r_out_acc;
    logic [ROW_WIDTH-1:0]  r_l_iss;
    logic [ROW_WIDTH-1:0]  r_l_done;
    logic [ROW_WIDTH-1:0]  r_s_iss;
    logic [ROW_WIDTH-1:0]  r_s_done;
    logic                  r_in_req;
    logic [ADDR_WIDTH-1:0] r_in_addr;
    logic [LEN_WIDTH-1:0]  r_in_len;
    logic                  r_out_req;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [LEN_WIDTH-1:0]  r_out_len;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_ack;
    logic                  w_out_ack;
    logic [ROW_WIDTH-1:0]  w_l_done_nx;
    logic [ROW_WIDTH-1:0]  w_s_done_nx;
    logic [ROW_WIDTH-1:0]  w_ahead;
    logic                  w_ld_go;
    logic                  w_st_go;
    logic                  w_empty_job;

    // Issue decisions look at this cycle's done pulses so requests are registered one cycle later.
    always_comb begin
        w_in_ack    = (r_state == S_RUN) && strm.in_done_i && (r_l_iss != r_l_done);
        w_out_ack   = (r_state == S_RUN) && strm.out_done_i && (r_s_iss != r_s_done);
        w_l_done_nx = w_in_ack ? r_l_done + ROW_ONE : r_l_done;
        w_s_done_nx = w_out_ack ? r_s_done + ROW_ONE : r_s_done;
        w_ahead     = r_l_iss - w_s_done_nx;
        w_ld_go     = (r_state == S_RUN) && (r_l_iss < r_n_rows) &&
                      (r_l_iss == w_l_done_nx) && (w_ahead < ROW_TWO);
        w_st_go     = (r_state == S_RUN) && (r_s_iss < w_l_done_nx) &&
                      (r_s_iss == w_s_done_nx);
        w_empty_job = (n_rows_i == '0) || (row_len_i == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state    <= S_IDLE;
            r_n_rows   <= '0;
            r_len      <= '0;
            r_stride   <= '0;
            r_in_acc   <= '0;
            r_out_acc  <= '0;
            r_l_iss    <= '0;
            r_l_done   <= '0;
            r_s_iss    <= '0;
            r_s_done   <= '0;
            r_in_req   <= 1'b0;
            r_in_addr  <= '0;
            r_in_len   <= '0;
            r_out_req  <= 1'b0;
            r_out_addr <= '0;
            r_out_len  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_req  <= 1'b0;
            r_out_req <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n_rows <= n_rows_i;
                        r_len    <= row_len_i;
                        r_stride <= row_stride_i;
                        r_l_done <= '0;
                        r_s_iss  <= '0;
                        r_s_done <= '0;
                        if (w_empty_job) begin
                            r_l_iss <= '0;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Row 0 load goes out immediately, so the load accumulator starts at row 1.
                            r_in_req  <= 1'b1;
                            r_in_addr <= in_base_i;
                            r_in_len  <= row_len_i;
                            r_in_acc  <= in_base_i + row_stride_i;
                            r_out_acc <= out_base_i;
                            r_l_iss   <= ROW_ONE;
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_l_done <= w_l_done_nx;
                    r_s_done <= w_s_done_nx;
                    if (w_ld_go) begin
                        r_in_req  <= 1'b1;
                        r_in_addr <= r_in_acc;
                        r_in_len  <= r_len;
                        r_in_acc  <= r_in_acc + r_stride;
                        r_l_iss   <= r_l_iss + ROW_ONE;
                    end
                    if (w_st_go) begin
                        r_out_req  <= 1'b1;
                        r_out_addr <= r_out_acc;
                        r_out_len  <= r_len;
                        r_out_acc  <= r_out_acc + r_stride;
                        r_s_iss    <= r_s_iss + ROW_ONE;
                    end
                    if (w_s_done_nx == r_n_rows) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign strm.in_req_start_o  = r_in_req;
    assign strm.in_addr_o       = r_in_addr;
    assign strm.in_len_o        = r_in_len;
    assign strm.out_req_start_o = r_out_req;
    assign strm.out_addr_o      = r_out_addr;
    assign strm.out_len_o       = r_out_len;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign rows_done_o          = r_s_done;
endmodule

// File: tb/tb_softex_streamer_sched.sv
// Directed bench for softex_streamer_sched: per-scenario tasks with hand-computed expectations.
module tb_softex_streamer_sched;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [31:0] in_base_i;
    logic [31:0] out_base_i;
    logic [31:0] row_stride_i;
    logic [15:0] row_len_i;
    logic [15:0] n_rows_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] rows_done_o;

    softex_streamer_sched_if #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) strm ();

    softex_streamer_sched #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .ROW_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .in_base_i    (in_base_i),
        .out_base_i   (out_base_i),
        .row_stride_i (row_stride_i),
        .row_len_i    (row_len_i),
        .n_rows_i     (n_rows_i),
        .strm         (strm),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rows_done_o  (rows_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    int          in_cyc_q[$];
    logic [31:0] in_addr_q[$];
    logic [15:0] in_len_q[$];
    int          out_cyc_q[$];
    logic [31:0] out_addr_q[$];
    logic [15:0] out_len_q[$];
    int          done_cnt;
    int          done_cyc;
    logic        busy_first;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Starts a job in the current cycle (cycle 0) and plays single-cycle done responders.
    // Store completions are withheld until cycle out_hold; glitch_cyc re-pulses start with new bases.
    task automatic drive_job(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] st,
                             input logic [15:0] ln, input logic [15:0] nr,
                             input int out_hold, input int glitch_cyc, input int budget);
        logic pend_in;
        logic pend_out;
        in_cyc_q.delete(); in_addr_q.delete(); in_len_q.delete();
        out_cyc_q.delete(); out_addr_q.delete(); out_len_q.delete();
        done_cnt = 0; done_cyc = -1; busy_first = 1'b0;
        pend_in = 1'b0; pend_out = 1'b0;
        in_base_i = ib; out_base_i = ob; row_stride_i = st; row_len_i = ln; n_rows_i = nr;
        start_i = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            step();
            start_i = 1'b0;
            if (k == glitch_cyc) begin
                start_i    = 1'b1;
                in_base_i  = 32'hdead_0000;
                out_base_i = 32'hbeef_0000;
            end
            strm.in_done_i = pend_in;
            pend_in = 1'b0;
            strm.out_done_i = 1'b0;
            if (pend_out && k >= out_hold) begin
                strm.out_done_i = 1'b1;
                pend_out = 1'b0;
            end
            if (strm.in_req_start_o) begin
                in_cyc_q.push_back(k); in_addr_q.push_back(strm.in_addr_o);
                in_len_q.push_back(strm.in_len_o);
                pend_in = 1'b1;
            end
            if (strm.out_req_start_o) begin
                out_cyc_q.push_back(k); out_addr_q.push_back(strm.out_addr_o);
                out_len_q.push_back(strm.out_len_o);
                pend_out = 1'b1;
            end
            if (k == 1) busy_first = busy_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        start_i = 1'b0;
        strm.in_done_i = 1'b0;
        strm.out_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        checks++;
        if ({busy_o, done_o, strm.in_req_start_o, strm.out_req_start_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000",
                {busy_o, done_o, strm.in_req_start_o, strm.out_req_start_o});
        end
        checks++;
        if ({strm.in_addr_o, strm.out_addr_o, strm.in_len_o, strm.out_len_o, rows_done_o} !== '0) begin
            failures++; $display("FAIL reset_values in=%h out=%h rows=%0d exp=0",
                strm.in_addr_o, strm.out_addr_o, rows_done_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic_job();
        logic [31:0] exp_in[3];
        logic [31:0] exp_out[3];
        exp_in  = '{32'h1000, 32'h1040, 32'h1080};
        exp_out = '{32'h2000, 32'h2040, 32'h2080};
        drive_job(32'h1000, 32'h2000, 32'h40, 16'h40, 16'd3, 0, -1, 40);
        checks++;
        if (in_addr_q.size() != 3 || out_addr_q.size() != 3) begin
            failures++; $display("FAIL basic_counts loads=%0d stores=%0d exp=3/3",
                in_addr_q.size(), out_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (in_addr_q[i] !== exp_in[i] || out_addr_q[i] !== exp_out[i] ||
                    in_len_q[i] !== 16'h40 || out_len_q[i] !== 16'h40) begin
                    failures++; $display("FAIL basic_row%0d in=%h out=%h len=%h/%h exp=%h/%h len 40",
                        i, in_addr_q[i], out_addr_q[i], in_len_q[i], out_len_q[i], exp_in[i], exp_out[i]);
                end
            end
            checks++;
            if (in_cyc_q[0] != 1) begin
                failures++; $display("FAIL first_load_cycle got=%0d exp=1", in_cyc_q[0]);
            end
            // Cycle 4 carries both in_done and out_done; both streams must reissue in cycle 5.
            checks++;
            if (in_cyc_q[2] != 5 || out_cyc_q[1] != 5) begin
                failures++; $display("FAIL dual_done_reissue load=%0d store=%0d exp=5/5",
                    in_cyc_q[2], out_cyc_q[1]);
            end
        end
        checks++;
        if (busy_first !== 1'b1) begin
            failures++; $display("FAIL basic_busy got=%b exp=1", busy_first);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 9) begin
            failures++; $display("FAIL basic_done count=%0d cycle=%0d exp=1/9", done_cnt, done_cyc);
        end
        checks++;
        if (rows_done_o !== 16'd3 || busy_o !== 1'b0) begin
            failures++; $display("FAIL basic_rows_done got=%0d busy=%b exp=3/0", rows_done_o, busy_o);
        end
    endtask

    task automatic test_store_backpressure();
        drive_job(32'h1000, 32'h2000, 32'h40, 16'h40, 16'd3, 10, -1, 60);
        checks++;
        if (in_cyc_q.size() != 3) begin
            failures++; $display("FAIL bp_load_count got=%0d exp=3", in_cyc_q.size());
        end else begin
            checks++;
            if (in_cyc_q[1] != 3 || in_cyc_q[2] != 11) begin
                failures++; $display("FAIL bp_load_cycles got=%0d,%0d exp=3,11", in_cyc_q[1], in_cyc_q[2]);
            end
            checks++;
            if (in_addr_q[2] !== 32'h1080) begin
                failures++; $display("FAIL bp_third_addr got=%h exp=00001080", in_addr_q[2]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 15 || rows_done_o !== 16'd3) begin
            failures++; $display("FAIL bp_done count=%0d cycle=%0d rows=%0d exp=1/15/3",
                done_cnt, done_cyc, rows_done_o);
        end
    endtask

    task automatic test_empty_jobs();
        drive_job(32'h1000, 32'h2000, 32'h40, 16'h40, 16'd0, 0, -1, 10);
        checks++;
        if (done_cnt != 1 || done_cyc != 1 || in_cyc_q.size() != 0 || out_cyc_q.size() != 0 ||
            busy_first !== 1'b0) begin
            failures++; $display("FAIL zero_rows done=%0d cyc=%0d loads=%0d stores=%0d busy=%b exp=1/1/0/0/0",
                done_cnt, done_cyc, in_cyc_q.size(), out_cyc_q.size(), busy_first);
        end
        checks++;
        if (rows_done_o !== 16'd0) begin
            failures++; $display("FAIL zero_rows_done got=%0d exp=0", rows_done_o);
        end
        drive_job(32'h1000, 32'h2000, 32'h40, 16'h0, 16'd3, 0, -1, 10);
        checks++;
        if (done_cnt != 1 || done_cyc != 1 || in_cyc_q.size() != 0 || out_cyc_q.size() != 0) begin
            failures++; $display("FAIL zero_len done=%0d cyc=%0d loads=%0d stores=%0d exp=1/1/0/0",
                done_cnt, done_cyc, in_cyc_q.size(), out_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        logic        done_seen;
        logic [31:0] exp_in[3];
        in_base_i = 32'h1000; out_base_i = 32'h2000; row_stride_i = 32'h40;
        row_len_i = 16'h40; n_rows_i = 16'd3;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        strm.in_done_i = 1'b1;
        step();
        strm.in_done_i = 1'b0;
        checks++;
        if (strm.out_req_start_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++; $display("FAIL rst_pre_store got=%b busy=%b exp=1/1", strm.out_req_start_o, busy_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if ({busy_o, done_o, strm.in_req_start_o, strm.out_req_start_o} !== 4'b0000 ||
            {strm.in_addr_o, strm.out_addr_o, strm.in_len_o, strm.out_len_o, rows_done_o} !== '0) begin
            failures++; $display("FAIL rst_mid_run busy=%b in=%h out=%h rows=%0d exp=all 0",
                busy_o, strm.in_addr_o, strm.out_addr_o, rows_done_o);
        end
        strm.in_done_i = 1'b1;
        strm.out_done_i = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            strm.in_done_i = 1'b0;
            strm.out_done_i = 1'b0;
            if (done_o || busy_o || strm.in_req_start_o || strm.out_req_start_o) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0 || rows_done_o !== 16'd0) begin
            failures++; $display("FAIL rst_stray_done activity=%b rows=%0d exp=0/0", done_seen, rows_done_o);
        end
        // New job after the abort, with load addresses wrapping past 2^32.
        exp_in = '{32'hFFFF_FF80, 32'hFFFF_FFC0, 32'h0000_0000};
        drive_job(32'hFFFF_FF80, 32'h7000, 32'h40, 16'h10, 16'd3, 0, -1, 40);
        checks++;
        if (in_addr_q.size() != 3 || out_addr_q.size() != 3) begin
            failures++; $display("FAIL rst_rerun_counts loads=%0d stores=%0d exp=3/3",
                in_addr_q.size(), out_addr_q.size());
        end else begin
            checks++;
            if (in_addr_q[0] !== exp_in[0] || in_addr_q[1] !== exp_in[1] || in_addr_q[2] !== exp_in[2]) begin
                failures++; $display("FAIL rst_rerun_in got=%h,%h,%h exp=%h,%h,%h",
                    in_addr_q[0], in_addr_q[1], in_addr_q[2], exp_in[0], exp_in[1], exp_in[2]);
            end
            checks++;
            if (out_addr_q[0] !== 32'h7000 || out_addr_q[1] !== 32'h7040 || out_addr_q[2] !== 32'h7080 ||
                out_len_q[2] !== 16'h10) begin
                failures++; $display("FAIL rst_rerun_out got=%h,%h,%h len=%h exp=7000,7040,7080 len 10",
                    out_addr_q[0], out_addr_q[1], out_addr_q[2], out_len_q[2]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 9 || rows_done_o !== 16'd3) begin
            failures++; $display("FAIL rst_rerun_done count=%0d cycle=%0d rows=%0d exp=1/9/3",
                done_cnt, done_cyc, rows_done_o);
        end
    endtask

    task automatic test_clear_mid_run();
        logic done_seen;
        in_base_i = 32'h3000; out_base_i = 32'h4000; row_stride_i = 32'h20;
        row_len_i = 16'h20; n_rows_i = 16'd2;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        strm.in_done_i = 1'b1;
        clear_i = 1'b1;
        step();
        strm.in_done_i = 1'b0;
        clear_i = 1'b0;
        checks++;
        if ({busy_o, strm.in_req_start_o, strm.out_req_start_o} !== 3'b000 || strm.in_addr_o !== 32'h0) begin
            failures++; $display("FAIL clear_mid_run busy=%b reqs=%b%b in=%h exp=0/00/0",
                busy_o, strm.in_req_start_o, strm.out_req_start_o, strm.in_addr_o);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done_o || busy_o) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++; $display("FAIL clear_no_done got=%b exp=0", done_seen);
        end
    endtask

    task automatic test_start_in_run_and_idle_stray();
        logic [31:0] exp_in[4];
        logic [31:0] exp_out[4];
        logic        activity;
        exp_in  = '{32'h5000, 32'h5100, 32'h5200, 32'h5300};
        exp_out = '{32'h9000, 32'h9100, 32'h9200, 32'h9300};
        drive_job(32'h5000, 32'h9000, 32'h100, 16'h24, 16'd4, 0, 4, 40);
        checks++;
        if (in_addr_q.size() != 4 || out_addr_q.size() != 4) begin
            failures++; $display("FAIL restart_counts loads=%0d stores=%0d exp=4/4",
                in_addr_q.size(), out_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (in_addr_q[i] !== exp_in[i] || out_addr_q[i] !== exp_out[i] || in_len_q[i] !== 16'h24) begin
                    failures++; $display("FAIL restart_row%0d in=%h out=%h len=%h exp=%h/%h len 24",
                        i, in_addr_q[i], out_addr_q[i], in_len_q[i], exp_in[i], exp_out[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 11 || rows_done_o !== 16'd4) begin
            failures++; $display("FAIL restart_done count=%0d cycle=%0d rows=%0d exp=1/11/4",
                done_cnt, done_cyc, rows_done_o);
        end
        activity = 1'b0;
        for (int k = 0; k < 4; k++) begin
            strm.in_done_i = (k == 0);
            strm.out_done_i = (k == 1);
            step();
            if (busy_o || done_o || strm.in_req_start_o || strm.out_req_start_o) activity = 1'b1;
        end
        strm.in_done_i = 1'b0;
        strm.out_done_i = 1'b0;
        checks++;
        if (activity !== 1'b0 || rows_done_o !== 16'd4 || strm.in_addr_o !== 32'h5300) begin
            failures++; $display("FAIL idle_stray activity=%b rows=%0d in=%h exp=0/4/5300",
                activity, rows_done_o, strm.in_addr_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        in_base_i = '0; out_base_i = '0; row_stride_i = '0; row_len_i = '0; n_rows_i = '0;
        strm.in_done_i = 1'b0;
        strm.out_done_i = 1'b0;
        test_reset();
        test_basic_job();
        test_store_backpressure();
        test_empty_jobs();
        test_reset_mid_run();
        test_clear_mid_run();
        test_start_in_run_and_idle_stray();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
